// File: rtl/display_timing_if.sv
// Panel-side bundle for display_timing: pixel-enable, mode and fetch data in,
// counters, sync/DE timing and panel colour out.
interface display_timing_if #(
   parameter int CW = 11
);
   logic          pce;
   logic [1:0]    mode;
   logic [15:0]   pixel_in;
   logic [CW-1:0] px_x;
   logic [CW-1:0] px_y;
   logic          hsync;
   logic          vsync;
   logic          de;
   logic [15:0]   color;
   logic          frame_start;
   logic          line_start;

   modport master (
      input  pce, mode, pixel_in,
      output px_x, px_y, hsync, vsync, de, color, frame_start, line_start
   );

   modport slave (
      output pce, mode, pixel_in,
      input  px_x, px_y, hsync, vsync, de, color, frame_start, line_start
   );
endinterface

// File: rtl/display_timing.sv
// Parametrised RGB565 panel timing generator with frame-buffer fetch re-alignment
// and built-in test patterns (bars, checker, solid).
module display_timing #(
   parameter int CW        = 11,
   parameter int WIDTH     = 480,
   parameter int HEIGHT    = 480,
   parameter int H_FP      = 8,
   parameter int H_PW      = 20,
   parameter int H_BP      = 8,
   parameter int V_FP      = 8,
   parameter int V_PW      = 2,
   parameter int V_BP      = 8,
   parameter bit H_POL     = 1'b0,
   parameter bit V_POL     = 1'b0,
   parameter int FETCH_LAT = 2,
   parameter int BAR_W     = 60,
   parameter int CHK_LOG2  = 4
) (
   input  logic             clk,
   input  logic             reset,
   display_timing_if.master bus
);

   localparam int H_TOTAL = WIDTH + H_FP + H_PW + H_BP;
   localparam int V_TOTAL = HEIGHT + V_FP + V_PW + V_BP;
   localparam int HS_BEG  = WIDTH + H_FP;
   localparam int HS_END  = WIDTH + H_FP + H_PW;
   localparam int VS_BEG  = HEIGHT + V_FP;
   localparam int VS_END  = HEIGHT + V_FP + V_PW;
   localparam logic [CW-1:0] H_LAST   = CW'(H_TOTAL - 1);
   localparam logic [CW-1:0] V_LAST   = CW'(V_TOTAL - 1);
   localparam logic [CW-1:0] BAR_LAST = CW'(BAR_W - 1);

   typedef enum logic [1:0] {
      MODE_PASS  = 2'd0,
      MODE_BARS  = 2'd1,
      MODE_CHECK = 2'd2,
      MODE_SOLID = 2'd3
   } mode_t;

   typedef struct packed {
      logic        de;
      logic        hs;
      logic        vs;
      logic        fs;
      logic        ls;
      mode_t       mode;
      logic [15:0] pat;
   } attr_t;

   logic [CW-1:0] col, row, bar_px;
   logic [2:0]    bar_idx;
   mode_t         act_mode;
   attr_t         s0, fin;
   logic          h_wrap, v_wrap;

   assign h_wrap   = (col == H_LAST);
   assign v_wrap   = (row == V_LAST);
   assign bus.px_x = col;
   assign bus.px_y = row;

   function automatic logic [15:0] bar_colour(input logic [2:0] idx);
      case (idx)
         3'd0:    return 16'hffff;
         3'd1:    return 16'hffe0;
         3'd2:    return 16'h07ff;
         3'd3:    return 16'h07e0;
         3'd4:    return 16'hf81f;
         3'd5:    return 16'hf800;
         3'd6:    return 16'h001f;
         default: return 16'h0000;
      endcase
   endfunction

   // Bar position tracked incrementally alongside col so no divider is needed;
   // the 3-bit index wraps naturally after the eighth bar.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         col      <= '0;
         row      <= '0;
         bar_px   <= '0;
         bar_idx  <= '0;
         act_mode <= MODE_PASS;
      end else if (bus.pce) begin
         if (h_wrap) begin
            col     <= '0;
            bar_px  <= '0;
            bar_idx <= '0;
            row     <= v_wrap ? '0 : row + 1'b1;
            if (v_wrap) act_mode <= mode_t'(bus.mode);
         end else begin
            col <= col + 1'b1;
            if (bar_px == BAR_LAST) begin
               bar_px  <= '0;
               bar_idx <= bar_idx + 1'b1;
            end else begin
               bar_px <= bar_px + 1'b1;
            end
         end
      end
   end

   always_comb begin
      s0      = '0;
      s0.de   = (int'(col) < WIDTH) && (int'(row) < HEIGHT);
      s0.hs   = (int'(col) >= HS_BEG) && (int'(col) < HS_END);
      s0.vs   = (int'(row) >= VS_BEG) && (int'(row) < VS_END);
      s0.fs   = (col == '0) && (row == '0);
      s0.ls   = (col == '0) && (int'(row) < HEIGHT);
      s0.mode = act_mode;
      case (act_mode)
         MODE_BARS:  s0.pat = bar_colour(bar_idx);
         MODE_CHECK: s0.pat = (col[CHK_LOG2] ^ row[CHK_LOG2]) ? 16'hffff : 16'h0000;
         MODE_SOLID: s0.pat = 16'h001f;
         default:    s0.pat = '0;
      endcase
   end

   // Attributes (including the latched mode) ride alongside the fetch latency.
   if (FETCH_LAT == 0) begin : g_nopipe
      assign fin = s0;
   end else begin : g_pipe
      attr_t pipe [FETCH_LAT];

      always_ff @(posedge clk or posedge reset) begin
         if (reset) begin
            for (int unsigned i = 0; i < FETCH_LAT; i++) pipe[i] <= '0;
         end else if (bus.pce) begin
            pipe[0] <= s0;
            for (int unsigned i = 1; i < FETCH_LAT; i++) pipe[i] <= pipe[i-1];
         end
      end

      assign fin = pipe[FETCH_LAT-1];
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         bus.de          <= 1'b0;
         bus.color       <= '0;
         bus.hsync       <= ~H_POL;
         bus.vsync       <= ~V_POL;
         bus.frame_start <= 1'b0;
         bus.line_start  <= 1'b0;
      end else begin
         bus.frame_start <= bus.pce && fin.fs;
         bus.line_start  <= bus.pce && fin.ls;
         if (bus.pce) begin
            bus.de    <= fin.de;
            bus.hsync <= fin.hs ? H_POL : ~H_POL;
            bus.vsync <= fin.vs ? V_POL : ~V_POL;
            if (!fin.de)                    bus.color <= '0;
            else if (fin.mode == MODE_PASS) bus.color <= bus.pixel_in;
            else                            bus.color <= fin.pat;
         end
      end
   end

endmodule

// File: tb/tb_display_timing.sv
// Scoreboard bench for display_timing: two small-panel instances (FETCH_LAT=2 and an
// inverted-sync FETCH_LAT=0 variant) driven together against a position model.
module tb_display_timing;

   typedef struct packed {
      logic        de;
      logic        hs;
      logic        vs;
      logic        fs;
      logic        ls;
      logic [15:0] color;
   } exp_t;

   localparam exp_t RST_A = '{1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 16'h0000};
   localparam exp_t RST_B = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 16'h0000};
   localparam logic [15:0] BARS [8] = '{16'hffff, 16'hffe0, 16'h07ff, 16'h07e0,
                                        16'hf81f, 16'hf800, 16'h001f, 16'h0000};

   logic clk = 1'b0;
   logic rst = 1'b0;
   always #5 clk = ~clk;

   display_timing_if #(.CW(11)) ifa ();
   display_timing_if #(.CW(11)) ifb ();

   display_timing #(
      .CW(11), .WIDTH(8), .HEIGHT(4), .H_FP(2), .H_PW(3), .H_BP(1),
      .V_FP(1), .V_PW(1), .V_BP(1), .H_POL(1'b0), .V_POL(1'b0),
      .FETCH_LAT(2), .BAR_W(1), .CHK_LOG2(1)
   ) dut_a (.clk(clk), .reset(rst), .bus(ifa));

   display_timing #(
      .CW(11), .WIDTH(8), .HEIGHT(4), .H_FP(2), .H_PW(3), .H_BP(1),
      .V_FP(1), .V_PW(1), .V_BP(1), .H_POL(1'b1), .V_POL(1'b1),
      .FETCH_LAT(0), .BAR_W(3), .CHK_LOG2(0)
   ) dut_b (.clk(clk), .reset(rst), .bus(ifb));

   int n_pass  = 0;
   int n_total = 0;

   exp_t        qa [$];
   exp_t        qb [$];
   logic [21:0] qpa [$];
   exp_t        last_a, last_b;

   int         m_col, m_row, hc1, hr1, hc2, hr2;
   logic [1:0] act, mode_in;

   task automatic chk(input string nm, input logic [31:0] act_v, input logic [31:0] exp_v);
      n_total++;
      if (act_v === exp_v) n_pass++;
      else $display("FAIL %s at %0t: got %h expected %h", nm, $time, act_v, exp_v);
   endtask

   task automatic chk_out(input string tag, input exp_t a, input exp_t e);
      chk({tag, " de"},          32'(a.de),    32'(e.de));
      chk({tag, " hsync"},       32'(a.hs),    32'(e.hs));
      chk({tag, " vsync"},       32'(a.vs),    32'(e.vs));
      chk({tag, " frame_start"}, 32'(a.fs),    32'(e.fs));
      chk({tag, " line_start"},  32'(a.ls),    32'(e.ls));
      chk({tag, " color"},       32'(a.color), 32'(e.color));
   endtask

   // Expected panel output for counter position (c,r) rendered in mode m.
   function automatic exp_t model(input int c, input int r, input logic [1:0] m,
                                  input bit hp, input bit vp, input int bw, input int ck);
      exp_t e;
      e.de = (c < 8) && (r < 4);
      e.hs = (c >= 10 && c < 13) ? hp : ~hp;
      e.vs = (r == 5) ? vp : ~vp;
      e.fs = (c == 0) && (r == 0);
      e.ls = (c == 0) && (r < 4);
      case (m)
         2'd0:    e.color = {r[7:0], c[7:0]};
         2'd1:    e.color = BARS[(c / bw) % 8];
         2'd2:    e.color = ((((c >> ck) ^ (r >> ck)) & 1) != 0) ? 16'hffff : 16'h0000;
         default: e.color = 16'h001f;
      endcase
      if (!e.de) e.color = 16'h0000;
      return e;
   endfunction

   function automatic exp_t sample_a();
      exp_t e;
      e.de = ifa.de; e.hs = ifa.hsync; e.vs = ifa.vsync;
      e.fs = ifa.frame_start; e.ls = ifa.line_start; e.color = ifa.color;
      return e;
   endfunction

   function automatic exp_t sample_b();
      exp_t e;
      e.de = ifb.de; e.hs = ifb.hsync; e.vs = ifb.vsync;
      e.fs = ifb.frame_start; e.ls = ifb.line_start; e.color = ifb.color;
      return e;
   endfunction

   task automatic step(input bit p);
      @(negedge clk);
      ifa.pce      = p;
      ifb.pce      = p;
      ifa.mode     = mode_in;
      ifb.mode     = mode_in;
      ifa.pixel_in = {8'(hr2), 8'(hc2)};
      ifb.pixel_in = {8'(m_row), 8'(m_col)};
      if (p) begin
         qa.push_back(model(m_col, m_row, act, 1'b0, 1'b0, 1, 1));
         qb.push_back(model(m_col, m_row, act, 1'b1, 1'b1, 3, 0));
         hc2 = hc1; hr2 = hr1; hc1 = m_col; hr1 = m_row;
         if (m_col == 13) begin
            m_col = 0;
            if (m_row == 6) begin
               m_row = 0;
               act   = mode_in;
            end else begin
               m_row++;
            end
         end else begin
            m_col++;
         end
         qpa.push_back({11'(m_row), 11'(m_col)});
      end
   endtask

   task automatic do_reset();
      ifa.pce = 1'b0;
      ifb.pce = 1'b0;
      rst     = 1'b1;
      m_col = 0; m_row = 0; act = 2'd0;
      hc1 = 0; hr1 = 0; hc2 = 0; hr2 = 0;
      qa.delete(); qb.delete(); qpa.delete();
      qa.push_back(RST_A);
      qa.push_back(RST_A);
      repeat (2) @(negedge clk);
      rst = 1'b0;
   endtask

   always @(posedge clk or posedge rst) begin : mon_a
      logic p, r;
      exp_t e;
      p = ifa.pce;
      r = rst;
      #1;
      if (r) begin
         last_a = RST_A;
         chk_out("A reset", sample_a(), RST_A);
         chk("A px reset", 32'({ifa.px_y, ifa.px_x}), 32'd0);
      end else if (p) begin
         if (qa.size() == 0) begin
            n_total++;
            $display("FAIL A scoreboard at %0t: output tick with no expected entry", $time);
         end else begin
            e = qa.pop_front();
            last_a = e;
            chk_out("A tick", sample_a(), e);
         end
         if (qpa.size() != 0) chk("A px", 32'({ifa.px_y, ifa.px_x}), 32'(qpa.pop_front()));
      end else begin
         e = last_a;
         e.fs = 1'b0;
         e.ls = 1'b0;
         chk_out("A hold", sample_a(), e);
      end
   end

   always @(posedge clk or posedge rst) begin : mon_b
      logic p, r;
      exp_t e;
      p = ifb.pce;
      r = rst;
      #1;
      if (r) begin
         last_b = RST_B;
         chk_out("B reset", sample_b(), RST_B);
      end else if (p) begin
         if (qb.size() == 0) begin
            n_total++;
            $display("FAIL B scoreboard at %0t: output tick with no expected entry", $time);
         end else begin
            e = qb.pop_front();
            last_b = e;
            chk_out("B tick", sample_b(), e);
         end
      end else begin
         e = last_b;
         e.fs = 1'b0;
         e.ls = 1'b0;
         chk_out("B hold", sample_b(), e);
      end
   end

   initial begin
      ifa.pce = 1'b0; ifb.pce = 1'b0;
      ifa.mode = 2'd0; ifb.mode = 2'd0;
      ifa.pixel_in = '0; ifb.pixel_in = '0;
      mode_in = 2'd3;
      #1 do_reset();

      // First frame renders pass-through (reset mode), later frames solid blue.
      repeat (200) step(1'b1);
      mode_in = 2'd0;
      repeat (120) step(1'b1);

      // Bars with pce on one clk in three.
      mode_in = 2'd1;
      for (int i = 0; i < 660; i++) step((i % 3) == 0);

      // Request checker mid-frame at (3,2); bars must persist until the next frame.
      for (int i = 0; i < 200 && !(m_row == 2 && m_col == 3); i++) step(1'b1);
      mode_in = 2'd2;
      repeat (150) step(1'b1);

      // Reset mid-line at (5,2).
      for (int i = 0; i < 200 && !(m_row == 2 && m_col == 5); i++) step(1'b1);
      @(negedge clk);
      #1 do_reset();
      mode_in = 2'd3;
      repeat (120) step(1'b1);

      @(negedge clk);
      ifa.pce = 1'b0;
      ifb.pce = 1'b0;
      repeat (3) @(negedge clk);
      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule

// File: doc/display_timing.md
# display_timing

Parametrised successor to the fixed-mode panel timing generator. It produces hsync, vsync and DE for an RGB565 panel from a pixel-clock enable, and presents pixel coordinates for a frame-buffer fetch. The returned pixel data is re-aligned through a FETCH_LAT-deep pipeline. It sits between the frame-buffer read port and the panel pins and adds selectable test patterns.

## Interface
- CW, 11: width of column/row counters and px_x/px_y
- WIDTH, 480 / HEIGHT, 480: active pixels per line / active lines per frame
- H_FP, 8 / H_PW, 20 / H_BP, 8: horizontal front porch, sync width, back porch (pixels)
- V_FP, 8 / V_PW, 2 / V_BP, 8: vertical front porch, sync width, back porch (lines)
- H_POL, 0 / V_POL, 0: active level of hsync / vsync
- FETCH_LAT, 2: pce ticks between px_x/px_y and valid pixel_in; legal range 0..4
- BAR_W, 60: colour-bar width in pixels (mode 1)
- CHK_LOG2, 4: checker square size = 2^CHK_LOG2 pixels (mode 2)
- clk  in  1  system clock
- reset  in  1  asynchronous, active-high reset
- pce  in  1  pixel clock enable; all state advances only when pce=1
- mode  in  2  0 pass-through, 1 colour bars, 2 checker, 3 solid blue
- pixel_in  in  16  RGB565 frame-buffer data
- px_x  out  CW  current column counter
- px_y  out  CW  current row counter
- hsync, vsync, de  out  1  panel timing (registered)
- color  out  16  RGB565 panel data (registered)
- frame_start, line_start  out  1  one-clk pulses aligned with the output stage

## Operation
- H_TOTAL = WIDTH+H_FP+H_PW+H_BP and V_TOTAL = HEIGHT+V_FP+V_PW+V_BP, both ≤ 2^CW.
- On pce, col increments; at H_TOTAL-1 col wraps to 0 and row increments; at V_TOTAL-1 row wraps to 0.
- px_x = col and px_y = row, driven directly from the counter registers.
- Stage-0 attributes are computed from the counters:
  - de0 = (col<WIDTH)&&(row<HEIGHT)
  - hs0 = col in [WIDTH+H_FP, WIDTH+H_FP+H_PW)
  - vs0 = row in [HEIGHT+V_FP, HEIGHT+V_FP+V_PW)
  - fs0 = (col==0&&row==0)
  - ls0 = (col==0&&row<HEIGHT)
  - pattern colour for (col,row)
- Attributes shift through FETCH_LAT pipeline stages on each pce. The final stage registers into the outputs on pce.
- At that final capture the colour source is chosen:
  - mode 0: pixel_in.
  - Other modes: the pattern colour carried through the pipeline.
  - color is forced to 0 whenever the captured de is 0.
- Output polarity: hsync = hs ? H_POL : ~H_POL; vsync likewise with V_POL.
- Mode 1 bars: a bar counter resets at col 0 and advances every BAR_W pixels. Colours are, in order: ffff, ffe0, 07ff, 07e0, f81f, f800, 001f, 0000. Bars beyond 8 repeat from ffff. No dividers.
- Mode 2 checker: col[CHK_LOG2]^row[CHK_LOG2] ? ffff : 0000.
- Mode 3 solid: 001f.
- Mode latch:
  - mode is latched into the active mode register only on the pce tick where the counters wrap to (0,0).
  - A change mid-frame takes effect on the next frame's first pixel.
  - The latched mode travels with each pixel, so there is no mixed-mode pixel at the pipeline boundary.
- frame_start and line_start are high for exactly one clk cycle: the cycle following the pce capture of an fs/ls stage. They are low otherwise, even while pce stays low.

## Timing
- Reset values (immediate, async):
  - col = row = 0; all pipeline stages cleared.
  - de = 0, color = 0, hsync = ~H_POL, vsync = ~V_POL.
  - frame_start = line_start = 0; active mode = 0.
- Latency: the attributes of counter state (x,y) present in pce tick n appear on outputs after the pce tick n+FETCH_LAT, i.e. FETCH_LAT+1 ticks after px_x/px_y.
- pixel_in must be valid during pce tick n+FETCH_LAT. With FETCH_LAT=0 it is sampled in the same tick as px_x/px_y.
- With pce=0 every register holds, except frame_start/line_start, which drop to 0.
- Reset asserted mid-frame: outputs go to reset values immediately. After release, the first pce tick presents (0,0).
- The first frame after reset shows FETCH_LAT+1 ticks of reset-value outputs (de=0) before (0,0) arrives.

## Test plan
- Small configuration: WIDTH=8, HEIGHT=4, H_FP=2, H_PW=3, H_BP=1, V_FP=V_PW=V_BP=1, FETCH_LAT=2, pce=1, mode 3.
  - Per line: de high 8 cycles of every 14, and hsync low for columns 10..12 (output cycles offset +3).
  - Per frame (98 cycles): vsync low for row 5, and frame_start pulses every 98 cycles.
- Mode 0, pixel_in = {px_y[7:0], px_x[7:0]} delayed by 2 ticks: color at output (3,1) equals 16'h0103, and color = 0 during blanking.
- pce toggled 1-of-3 cycles: outputs change only after pce ticks, and frame_start is 1 clk wide. The frame period is 294 clk.
- mode switched 1→2 at col 3 of row 2: the remainder of that frame is bars. Checker starts exactly at the frame_start of the next frame.
- reset pulsed mid-line (row 2, col 5): hsync/vsync go inactive and de/color go 0 in the same cycle. After release, px_x = px_y = 0 on the first pce tick and de rises 3 ticks later.
- H_POL=1, V_POL=1, FETCH_LAT=0: sync pulses are inverted at the same positions, and latency is 1 tick.
